// File: rtl/nn_layer_seq.sv
// nn_layer_seq: control sequencer for a multi-layer MAC datapath.
// Runs COMPUTE -> DRAIN -> RESCALE -> ACTIVATE -> LOAD -> MAC_RST for each
// layer. It keeps a global weight address, a per-layer input index and the
// current layer number.
module nn_layer_seq #(
  parameter int NUM_LAYERS = 3,
  parameter int N_IN       = 784,
  parameter int N_HID      = 28,
  parameter int MAC_LAT    = 2,
  parameter int ADDR_W     = 11
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  cont,
  input  logic                                  mem_ready,
  input  logic                                  load_done,
  input  logic                                  abort,
  output logic [ADDR_W-1:0]                     ADDR,
  output logic [ADDR_W-1:0]                     ADDR_IP,
  output logic [$clog2(NUM_LAYERS+1)-1:0]       layer,
  output logic                                  mac_en,
  output logic                                  mac_rst,
  output logic                                  rescale,
  output logic                                  act_en,
  output logic                                  load_en,
  output logic                                  busy,
  output logic                                  done
);

  localparam int LW = $clog2(NUM_LAYERS + 1);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam longint TOTAL_BEATS = longint'(N_IN) + longint'(NUM_LAYERS - 1) * longint'(N_HID);
  localparam longint ADDR_SPACE  = longint'(1) << ADDR_W;

  if (NUM_LAYERS < 1) begin : g_bad_layers
    $error("nn_layer_seq: NUM_LAYERS must be >= 1");
  end
  if (MAC_LAT < 0) begin : g_bad_lat
    $error("nn_layer_seq: MAC_LAT must be >= 0");
  end
  if (TOTAL_BEATS > ADDR_SPACE) begin : g_bad_addr
    $error("nn_layer_seq: total weight beats exceed the ADDR_W address space");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_COMPUTE, S_DRAIN, S_RESCALE, S_ACTIVATE, S_LOAD, S_MAC_RST, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic            aborting;
  logic            abort_take;
  logic [DW-1:0]   drain_cnt;
  logic [ADDR_W-1:0] fan_last;
  logic            last_beat;
  logic            run_clear;

  assign fan_last   = (layer == '0) ? ADDR_W'(N_IN - 1) : ADDR_W'(N_HID - 1);
  assign last_beat  = (ADDR_IP == fan_last);
  // A MAC_RST entered because of an abort must not be re-entered by a held abort.
  assign abort_take = abort && (state != S_IDLE) && !((state == S_MAC_RST) && aborting);
  assign run_clear  = (state_nx == S_COMPUTE) && ((state == S_IDLE) || (state == S_DONE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Remember that the coming MAC_RST cycle is an abort, so it exits to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) aborting <= 1'b0;
    else     aborting <= abort_take;
  end

  // Next-state logic; abort takes priority over every other condition
  always_comb begin
    state_nx = state;
    if (abort_take) begin
      state_nx = S_MAC_RST;
    end else begin
      unique case (state)
        S_IDLE:     if (start && !abort) state_nx = S_COMPUTE;
        S_COMPUTE:  if (mem_ready && last_beat) state_nx = (MAC_LAT == 0) ? S_RESCALE : S_DRAIN;
        S_DRAIN:    if (drain_cnt == DRAIN_LAST) state_nx = S_RESCALE;
        S_RESCALE:  state_nx = S_ACTIVATE;
        S_ACTIVATE: state_nx = S_LOAD;
        S_LOAD:     if (load_done) state_nx = S_MAC_RST;
        S_MAC_RST: begin
          if (aborting)                 state_nx = S_IDLE;
          else if (layer == LAST_LAYER) state_nx = S_DONE;
          else                          state_nx = S_COMPUTE;
        end
        S_DONE:     state_nx = cont ? S_COMPUTE : S_IDLE;
        default:    state_nx = S_IDLE;
      endcase
    end
  end

  // Address, input index and layer counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ADDR    <= '0;
      ADDR_IP <= '0;
      layer   <= '0;
    end else if (run_clear) begin
      ADDR    <= '0;
      ADDR_IP <= '0;
      layer   <= '0;
    end else if ((state == S_COMPUTE) && mem_ready && !abort) begin
      ADDR <= ADDR + 1'b1;
      if (!last_beat) ADDR_IP <= ADDR_IP + 1'b1;
    end else if ((state == S_MAC_RST) && (state_nx == S_COMPUTE)) begin
      layer   <= layer + 1'b1;
      ADDR_IP <= '0;
    end
  end

  // Pipeline drain timer, restarted on every entry to DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  drain_cnt <= '0;
    else if (state != S_DRAIN) drain_cnt <= '0;
    else                      drain_cnt <= drain_cnt + 1'b1;
  end

  // Moore strobes decoded from the registered state; mac_en also gated by mem_ready
  always_comb begin
    mac_en  = (state == S_COMPUTE) && mem_ready;
    mac_rst = (state == S_MAC_RST);
    rescale = (state == S_RESCALE);
    act_en  = (state == S_ACTIVATE);
    load_en = (state == S_LOAD);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Scoreboard bench for nn_layer_seq: a per-inference timeline built from the
// layer rules predicts every MAC beat, LOAD length and done time.
module tb_nn_layer_seq;

  localparam int NL = 3;
  localparam int NIN = 784;
  localparam int NHID = 28;
  localparam int ML = 2;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, cont = 1'b0, mem_ready = 1'b0, load_done = 1'b0, abort = 1'b0;
  logic [AW-1:0] ADDR, ADDR_IP;
  logic [1:0]    layer;
  logic mac_en, mac_rst, rescale, act_en, load_en, busy, done;

  logic start1 = 1'b0;
  logic tie0 = 1'b0, tie1 = 1'b1;
  logic [AW-1:0] ADDR1, ADDR_IP1;
  logic [0:0]    layer1;
  logic mac_en1, mac_rst1, rescale1, act_en1, load_en1, busy1, done1;

  always #5 clk = ~clk;

  nn_layer_seq #(.NUM_LAYERS(NL), .N_IN(NIN), .N_HID(NHID), .MAC_LAT(ML), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mem_ready(mem_ready),
    .load_done(load_done), .abort(abort), .ADDR(ADDR), .ADDR_IP(ADDR_IP), .layer(layer),
    .mac_en(mac_en), .mac_rst(mac_rst), .rescale(rescale), .act_en(act_en),
    .load_en(load_en), .busy(busy), .done(done));

  nn_layer_seq #(.NUM_LAYERS(1), .N_IN(NIN), .N_HID(NHID), .MAC_LAT(0), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(tie0), .mem_ready(tie1),
    .load_done(tie1), .abort(tie0), .ADDR(ADDR1), .ADDR_IP(ADDR_IP1), .layer(layer1),
    .mac_en(mac_en1), .mac_rst(mac_rst1), .rescale(rescale1), .act_en(act_en1),
    .load_en(load_en1), .busy(busy1), .done(done1));

  typedef struct { int addr; int ip; int lyr; } beat_t;
  typedef struct { int cyc; int addr; } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  int    ld_q[$];
  bit    mr_tl[$];
  bit    ld_tl[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit sb_en = 1'b1;
  int ld_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat, a LOAD run or done
  always @(negedge clk) begin
    if (!rst && sb_en) begin
      if (mac_en) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_addr", ADDR, b.addr);
          chk("beat_ip", ADDR_IP, b.ip);
          chk("beat_layer", layer, b.lyr);
        end
      end
      if (load_en) ld_run++;
      else if (ld_run > 0) begin
        if (ld_q.size() == 0) chk("load_unexpected", ld_run, 0);
        else chk("load_len", ld_run, ld_q.pop_front());
        ld_run = 0;
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_addr", ADDR, d.addr);
          chk("done_busy", busy, 1);
        end
      end
    end
  end

  // Build one inference timeline (input drive per cycle) and its expectations.
  // E is the edge on which the inference leaves IDLE/DONE for COMPUTE.
  task automatic build(input int E, input bit stalls, input int maxw);
    int g;
    int fan;
    int s;
    int w;
    mr_tl.delete();
    ld_tl.delete();
    g = 0;
    for (int l = 0; l < NL; l++) begin
      fan = (l == 0) ? NIN : NHID;
      for (int b = 0; b < fan; b++) begin
        s = (stalls && $urandom_range(0, 40) == 0) ? $urandom_range(1, 10) : 0;
        repeat (s) begin mr_tl.push_back(1'b0); ld_tl.push_back(1'($urandom)); end
        mr_tl.push_back(1'b1); ld_tl.push_back(1'($urandom));
        beat_q.push_back('{addr: g, ip: b, lyr: l});
        g++;
      end
      repeat (ML + 2) begin mr_tl.push_back(1'($urandom)); ld_tl.push_back(1'($urandom)); end
      w = $urandom_range(0, maxw);
      repeat (w) begin mr_tl.push_back(1'($urandom)); ld_tl.push_back(1'b0); end
      mr_tl.push_back(1'($urandom)); ld_tl.push_back(1'b1);
      ld_q.push_back(w + 1);
      mr_tl.push_back(1'($urandom)); ld_tl.push_back(1'($urandom));
    end
    done_q.push_back('{cyc: E + mr_tl.size(), addr: g % (1 << AW)});
  endtask

  task automatic play();
    for (int i = 0; i < mr_tl.size(); i++) begin
      mem_ready = mr_tl[i];
      load_done = ld_tl[i];
      start = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // n inferences; n>1 chains them with cont
  task automatic run(input int n, input bit stalls, input int maxw);
    int E;
    @(posedge clk); #1;
    start = 1'b1;
    cont = (n > 1);
    E = cyc + 1;
    for (int k = 0; k < n; k++) begin
      build(E, stalls, maxw);
      @(posedge clk); #1;
      start = 1'b0;
      play();
      cont = (k < n - 1);
      E = cyc + 1;
    end
    @(posedge clk); #1;
    cont = 1'b0;
  endtask

  initial begin
    int E;
    bit got;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_ip", ADDR_IP, 0);
    chk("rst_layer", layer, 0);
    chk("rst_strobes", {mac_en, mac_rst, rescale, act_en, load_en, done}, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    run(1, 1'b0, 0);
    run(1, 1'b1, 0);
    run(1, 1'b0, 6);
    run(2, 1'b0, 0);
    run(2, 1'b1, 6);

    // Abort in layer 1 with ADDR_IP=12, no stalls, immediate load_done
    @(posedge clk); #1;
    start = 1'b1;
    E = cyc + 1;
    for (int b = 0; b < NIN; b++) beat_q.push_back('{addr: b, ip: b, lyr: 0});
    for (int b = 0; b <= 12; b++) beat_q.push_back('{addr: NIN + b, ip: b, lyr: 1});
    ld_q.push_back(1);
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b1; load_done = 1'b1;
    repeat (NIN + ML + 4 + 12) @(posedge clk);
    #1; abort = 1'b1;
    @(negedge clk);
    chk("abort_layer", layer, 1);
    chk("abort_ip", ADDR_IP, 12);
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_macrst", mac_rst, 1);
    chk("abort_busy_hold", busy, 1);
    chk("abort_addr_frozen", ADDR, NIN + 12);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_no_done", done, 0);

    // start together with abort in IDLE is ignored
    @(posedge clk); #1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", busy, 0);

    run(1, 1'b1, 3);

    // Asynchronous reset mid-COMPUTE
    sb_en = 1'b0;
    @(posedge clk); #1; start = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (100) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_addr", ADDR, 0);
    chk("arst_ip", ADDR_IP, 0);
    chk("arst_macen", mac_en, 0);
    @(posedge clk); #3; rst = 1'b0;
    @(negedge clk);
    chk("arst_still_idle", busy, 0);
    beat_q.delete(); done_q.delete(); ld_q.delete();
    ld_run = 0;
    sb_en = 1'b1;

    run(1, 1'b0, 2);

    // Single layer, no drain: done N_IN+4 edges after start
    @(posedge clk); #1; start1 = 1'b1; E = cyc + 1;
    @(posedge clk); #1; start1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done1) got = 1'b1;
    end
    if (!got) chk("dut1_done_timeout", 0, 1);
    else begin
      chk("dut1_done_cycle", cyc, E + NIN + 4);
      chk("dut1_addr", ADDR1, NIN);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("beat_q_empty", beat_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("ld_q_empty", ld_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_layer_seq.md
NN_LAYER_SEQ -- requirements
Module: nn_layer_seq

Interface
REQ-001 Parameter NUM_LAYERS, default 3: number of weight layers sequenced per inference (>=1).
REQ-002 Parameter N_IN, default 784: fan-in of layer 0.
REQ-003 Parameter N_HID, default 28: fan-in of layers 1..NUM_LAYERS-1.
REQ-004 Parameter MAC_LAT, default 2: MAC pipeline depth drained before rescale (>=0).
REQ-005 Parameter ADDR_W, default 11: width of address outputs.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 start  input  1  request an inference; sampled only in IDLE.
REQ-009 cont  input  1  continuous mode; when high at DONE, next inference starts without returning to IDLE.
REQ-010 mem_ready  input  1  operand memory ready; low stalls MAC beats.
REQ-011 load_done  input  1  activation write-back complete.
REQ-012 abort  input  1  synchronous abandon of current inference.
REQ-013 ADDR  output  ADDR_W  global weight address, contiguous across layers.
REQ-014 ADDR_IP  output  ADDR_W  input-vector index within current layer.
REQ-015 layer  output  clog2(NUM_LAYERS+1)  current layer index.
REQ-016 mac_en, mac_rst, rescale, act_en, load_en  output  1 each  datapath strobes.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse, inference complete.

Function
REQ-019 States SHALL be IDLE, COMPUTE, DRAIN, RESCALE, ACTIVATE, LOAD, MAC_RST, DONE; one-hot or binary encoding free.
REQ-020 IDLE: start=1 -> COMPUTE; ADDR, ADDR_IP, layer cleared to 0 on that edge.
REQ-021 COMPUTE: mac_en = mem_ready; on each cycle with mem_ready=1, ADDR and ADDR_IP increment by 1.
REQ-022 COMPUTE exits to DRAIN on the edge accepting beat fan_in-1 (fan_in = N_IN for layer 0, else N_HID); ADDR_IP is not incremented on that edge and is held in DRAIN.
REQ-023 DRAIN lasts exactly MAC_LAT cycles, mac_en=0; MAC_LAT=0 skips DRAIN.
REQ-024 RESCALE, ACTIVATE: one cycle each, rescale=1 and act_en=1 respectively.
REQ-025 LOAD: load_en=1 until load_done=1 sampled, then MAC_RST; no timeout.
REQ-026 MAC_RST: one cycle, mac_rst=1; if layer<NUM_LAYERS-1: layer+1, ADDR_IP=0, ADDR continues, -> COMPUTE; else -> DONE.
REQ-027 DONE: done=1 one cycle; cont=1 -> COMPUTE with ADDR, ADDR_IP, layer cleared; else -> IDLE.
REQ-028 All strobes, busy, done SHALL be Moore outputs decoded from registered state; never glitch on mem_ready except mac_en.
REQ-029 abort=1 in any non-IDLE state -> MAC_RST-equivalent cycle (mac_rst=1), then IDLE; no done pulse; abort overrides load_done and mem_ready.
REQ-030 start while busy is ignored; start and abort together in IDLE -> remain IDLE.
REQ-031 ADDR wraps modulo 2^ADDR_W; parameter sets where total beats exceed 2^ADDR_W are illegal (elaboration check).

Reset
REQ-032 rst=1 immediately forces IDLE; ADDR=0, ADDR_IP=0, layer=0, all strobes, busy, done =0; rst mid-inference discards progress without done.
REQ-033 First state transition after rst deassertion SHALL occur only on a clk edge with rst=0.

Verification
REQ-034 Defaults, mem_ready=1, load_done tied 1, start pulse at edge 0 -> done high in cycle after edge 858; ADDR ends at 840; layer steps 0,1,2.
REQ-035 mem_ready low 10 cycles mid-layer 0 -> mac_en low those cycles, ADDR frozen, done delayed exactly 10 cycles.
REQ-036 load_done held low 5 cycles in each LOAD -> load_en high 6 cycles each, done delayed 15 cycles.
REQ-037 abort at layer 1, ADDR_IP=12 -> one mac_rst cycle, IDLE, busy=0, no done; next start runs clean from ADDR=0.
REQ-038 cont=1 with start pulse -> back-to-back inferences, done pulses 859 cycles apart, busy never drops.
REQ-039 rst asserted asynchronously mid-COMPUTE -> outputs zero before next clk edge; NUM_LAYERS=1, MAC_LAT=0 -> done after N_IN+4 cycles.
